// File: rtl/cell_tile_fetch.sv
// cell_tile_fetch: maps the VGA pixel stream onto a minesweeper board,
// fetches each cell's state code, addresses the unified tile ROM and
// overlays a cursor border. Fixed latency of 4+ROM_LAT cycles, one pixel
// per cycle, no stalls.
module cell_tile_fetch #(
  parameter int unsigned        COLOR_W      = 16,
  parameter int unsigned        ORIGIN_X     = 192,
  parameter int unsigned        ORIGIN_Y     = 112,
  parameter int unsigned        CELL_W       = 32,
  parameter int unsigned        CELL_H       = 32,
  parameter int unsigned        GRID_COLS    = 8,
  parameter int unsigned        GRID_ROWS    = 8,
  parameter int unsigned        TILE_TYPES   = 12,
  parameter int unsigned        ROM_LAT      = 1,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 16'h0000,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = 16'hF800,
  localparam int unsigned       CW           = $clog2(GRID_COLS),
  localparam int unsigned       RW           = $clog2(GRID_ROWS),
  localparam int unsigned       RAW          = $clog2(TILE_TYPES * CELL_W * CELL_H)
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic [11:0]        pix_x,
  input  logic [11:0]        pix_y,
  input  logic               pix_de,
  input  logic               cursor_en,
  input  logic [CW-1:0]      cursor_col,
  input  logic [RW-1:0]      cursor_row,
  output logic               cell_rd_en,
  output logic [CW-1:0]      cell_rd_col,
  output logic [RW-1:0]      cell_rd_row,
  input  logic [3:0]         cell_code,
  output logic [RAW-1:0]     rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] pix_rgb,
  output logic               pix_rgb_vld
);

  localparam int unsigned OXW      = $clog2(CELL_W);
  localparam int unsigned OYW      = $clog2(CELL_H);
  localparam int unsigned GRID_W   = GRID_COLS * CELL_W;
  localparam int unsigned GRID_H   = GRID_ROWS * CELL_H;
  localparam int unsigned TILE_PIX = CELL_W * CELL_H;

  // Flag vector bit positions carried alongside the ROM access
  localparam int unsigned F_DE  = 3;
  localparam int unsigned F_IN  = 2;
  localparam int unsigned F_OK  = 1;
  localparam int unsigned F_HIT = 0;

  // ---------------------------------------------------------------- stage 0
  logic [31:0]    w_dx;
  logic [31:0]    w_dy;
  logic [31:0]    w_xbase;
  logic [31:0]    w_ybase;
  logic           w_in_grid;
  logic [CW-1:0]  w_col;
  logic [RW-1:0]  w_row;
  logic [OXW-1:0] w_ox;
  logic [OYW-1:0] w_oy;
  logic           w_border;
  logic           w_hit;

  // Cell index and in-cell offset of the incoming pixel. Division by the
  // constant cell size is done as a compare chain against its multiples,
  // so every pixel is resolved on its own with no running state.
  always_comb begin
    w_dx      = {20'd0, pix_x} - ORIGIN_X;
    w_dy      = {20'd0, pix_y} - ORIGIN_Y;
    w_in_grid = pix_de
             && ({20'd0, pix_x} >= ORIGIN_X) && ({20'd0, pix_x} < ORIGIN_X + GRID_W)
             && ({20'd0, pix_y} >= ORIGIN_Y) && ({20'd0, pix_y} < ORIGIN_Y + GRID_H);
    w_col   = '0;
    w_xbase = '0;
    for (int unsigned k = 1; k < GRID_COLS; k++) begin
      if (w_dx >= k * CELL_W) begin
        w_col   = CW'(k);
        w_xbase = k * CELL_W;
      end
    end
    w_row   = '0;
    w_ybase = '0;
    for (int unsigned k = 1; k < GRID_ROWS; k++) begin
      if (w_dy >= k * CELL_H) begin
        w_row   = RW'(k);
        w_ybase = k * CELL_H;
      end
    end
    w_ox = OXW'(w_dx - w_xbase);
    w_oy = OYW'(w_dy - w_ybase);
    if (!w_in_grid) begin
      w_col = '0;
      w_row = '0;
    end
    w_border = (w_ox == '0) || (w_ox == OXW'(CELL_W - 1))
            || (w_oy == '0) || (w_oy == OYW'(CELL_H - 1));
    w_hit    = w_in_grid && cursor_en && w_border
            && (w_col == cursor_col) && (w_row == cursor_row);
  end

  // ---------------------------------------------------------------- stage 1
  logic           r_rd_en;
  logic [CW-1:0]  r_rd_col;
  logic [RW-1:0]  r_rd_row;
  logic           r_s1_de;
  logic           r_s1_hit;
  logic [OXW-1:0] r_s1_ox;
  logic [OYW-1:0] r_s1_oy;

  // Issue the board-state read and capture per-pixel attributes
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_rd_en  <= 1'b0;
      r_rd_col <= '0;
      r_rd_row <= '0;
      r_s1_de  <= 1'b0;
      r_s1_hit <= 1'b0;
      r_s1_ox  <= '0;
      r_s1_oy  <= '0;
    end else begin
      r_rd_en  <= w_in_grid;
      r_rd_col <= w_col;
      r_rd_row <= w_row;
      r_s1_de  <= pix_de;
      r_s1_hit <= w_hit;
      r_s1_ox  <= w_ox;
      r_s1_oy  <= w_oy;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic           r_s2_de;
  logic           r_s2_in;
  logic           r_s2_hit;
  logic [OXW-1:0] r_s2_ox;
  logic [OYW-1:0] r_s2_oy;

  // Hold attributes while the board-state memory answers
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_s2_de  <= 1'b0;
      r_s2_in  <= 1'b0;
      r_s2_hit <= 1'b0;
      r_s2_ox  <= '0;
      r_s2_oy  <= '0;
    end else begin
      r_s2_de  <= r_s1_de;
      r_s2_in  <= r_rd_en;
      r_s2_hit <= r_s1_hit;
      r_s2_ox  <= r_s1_ox;
      r_s2_oy  <= r_s1_oy;
    end
  end

  logic           w_code_ok;
  logic [RAW-1:0] w_addr;

  // Tile ROM address from the returned code; constant multipliers only
  always_comb begin
    w_code_ok = r_s2_in && ({28'd0, cell_code} < TILE_TYPES);
    w_addr    = RAW'(TILE_PIX) * RAW'(cell_code)
              + RAW'(CELL_W) * RAW'(r_s2_oy)
              + RAW'(r_s2_ox);
  end

  // ------------------------------------------------- stage 3 + ROM latency
  logic [RAW-1:0] r_rom_addr;
  logic [3:0]     r_fl [0:ROM_LAT];

  // Register the ROM address and delay the pixel flags to meet rom_data
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_rom_addr <= '0;
      for (int unsigned i = 0; i <= ROM_LAT; i++) r_fl[i] <= '0;
    end else begin
      r_rom_addr <= w_code_ok ? w_addr : '0;
      r_fl[0]    <= {r_s2_de, r_s2_in, w_code_ok, r_s2_hit};
      for (int unsigned i = 1; i <= ROM_LAT; i++) r_fl[i] <= r_fl[i-1];
    end
  end

  // ------------------------------------------------------------ output
  logic [COLOR_W-1:0] r_rgb;
  logic               r_vld;

  // Final colour select: blank, background, cursor border, then tile pixel
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_rgb <= '0;
      r_vld <= 1'b0;
    end else if (!r_fl[ROM_LAT][F_DE]) begin
      r_rgb <= '0;
      r_vld <= 1'b0;
    end else if (!r_fl[ROM_LAT][F_IN] || !r_fl[ROM_LAT][F_OK]) begin
      r_rgb <= BG_COLOR;
      r_vld <= 1'b1;
    end else if (r_fl[ROM_LAT][F_HIT]) begin
      r_rgb <= CURSOR_COLOR;
      r_vld <= 1'b1;
    end else begin
      r_rgb <= rom_data;
      r_vld <= 1'b1;
    end
  end

  assign cell_rd_en  = r_rd_en;
  assign cell_rd_col = r_rd_col;
  assign cell_rd_row = r_rd_row;
  assign rom_addr    = r_rom_addr;
  assign pix_rgb     = r_rgb;
  assign pix_rgb_vld = r_vld;

endmodule

// File: tb/tb_cell_tile_fetch.sv
// Bench for cell_tile_fetch: two instances (ROM_LAT=1 and ROM_LAT=3) share
// one pixel stream. Expected read, address and pixel responses are queued
// with their due cycle and checked by an independent monitor.
module tb_cell_tile_fetch;

  localparam int OX   = 192;
  localparam int OY   = 112;
  localparam int CWID = 32;
  localparam int CHGT = 32;
  localparam int NCOL = 8;
  localparam int NROW = 8;
  localparam int NTIL = 12;
  localparam logic [15:0] BG  = 16'h0000;
  localparam logic [15:0] CUR = 16'hF800;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] v;
  } exp_t;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [11:0] pix_x, pix_y;
  logic        pix_de, cursor_en;
  logic [2:0]  cursor_col, cursor_row;

  logic        rd_en1, rd_en3;
  logic [2:0]  rd_col1, rd_row1, rd_col3, rd_row3;
  logic [3:0]  code1, code3;
  logic [13:0] addr1, addr3;
  logic [15:0] rom1, rom3, rgb1, rgb3;
  logic        vld1, vld3;

  logic [3:0]  board [NROW][NCOL];
  logic [15:0] rom1_q;
  logic [15:0] rom3_p [3];

  exp_t q_rd[$], q_ad[$], q_p1[$], q_p3[$];
  exp_t m_t;
  logic [31:0] m_e;

  int unsigned cyc = 0;
  bit          started = 1'b0;
  logic        rst_at_edge = 1'b0;
  int unsigned n_chk = 0, n_pass = 0;

  always #5 vga_clk = ~vga_clk;

  cell_tile_fetch #(.ROM_LAT(1)) u_dut1 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
    .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cell_rd_en(rd_en1), .cell_rd_col(rd_col1), .cell_rd_row(rd_row1),
    .cell_code(code1), .rom_addr(addr1), .rom_data(rom1),
    .pix_rgb(rgb1), .pix_rgb_vld(vld1)
  );

  cell_tile_fetch #(.ROM_LAT(3)) u_dut3 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
    .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cell_rd_en(rd_en3), .cell_rd_col(rd_col3), .cell_rd_row(rd_row3),
    .cell_code(code3), .rom_addr(addr3), .rom_data(rom3),
    .pix_rgb(rgb3), .pix_rgb_vld(vld3)
  );

  // Tile ROM contents: an address hash, distinct from BG and cursor colours
  function automatic logic [15:0] rom_f(input int unsigned a);
    logic [31:0] h;
    h = a * 32'd40503 + 32'd7919;
    return h[20:5] ^ a[15:0];
  endfunction

  // Board-state memory: one-cycle read, garbage when not read
  always @(posedge vga_clk) begin
    code1 <= rd_en1 ? board[rd_row1][rd_col1] : 4'($urandom);
    code3 <= rd_en3 ? board[rd_row3][rd_col3] : 4'($urandom);
  end

  // Tile ROMs with 1 and 3 cycles of latency
  always @(posedge vga_clk) begin
    rom1_q    <= rom_f({18'd0, addr1});
    rom3_p[0] <= rom_f({18'd0, addr3});
    rom3_p[1] <= rom3_p[0];
    rom3_p[2] <= rom3_p[1];
  end
  assign rom1 = rom1_q;
  assign rom3 = rom3_p[2];

  always @(posedge vga_clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= sys_rst_n;
    started     <= 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Monitor: compare DUT outputs against the entry due this cycle (or idle 0)
  always @(negedge vga_clk) begin
    if (started) begin
      if (!rst_at_edge) begin
        chk("rst_rd_addr1", {11'd0, rd_en1, rd_col1, rd_row1, addr1}, 32'd0);
        chk("rst_rd_addr3", {11'd0, rd_en3, rd_col3, rd_row3, addr3}, 32'd0);
        chk("rst_pix1", {15'd0, vld1, rgb1}, 32'd0);
        chk("rst_pix3", {15'd0, vld3, rgb3}, 32'd0);
      end else begin
        while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
          chk("rd_order", q_rd[0].cyc, cyc); m_t = q_rd.pop_front();
        end
        m_e = 32'd0;
        if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin m_t = q_rd.pop_front(); m_e = m_t.v; end
        chk("cell_rd1", {25'd0, rd_en1, rd_col1, rd_row1}, m_e);
        chk("cell_rd3", {25'd0, rd_en3, rd_col3, rd_row3}, m_e);

        while (q_ad.size() > 0 && q_ad[0].cyc < cyc) begin
          chk("addr_order", q_ad[0].cyc, cyc); m_t = q_ad.pop_front();
        end
        m_e = 32'd0;
        if (q_ad.size() > 0 && q_ad[0].cyc == cyc) begin m_t = q_ad.pop_front(); m_e = m_t.v; end
        chk("rom_addr1", {18'd0, addr1}, m_e);
        chk("rom_addr3", {18'd0, addr3}, m_e);

        while (q_p1.size() > 0 && q_p1[0].cyc < cyc) begin
          chk("pix1_order", q_p1[0].cyc, cyc); m_t = q_p1.pop_front();
        end
        m_e = 32'd0;
        if (q_p1.size() > 0 && q_p1[0].cyc == cyc) begin m_t = q_p1.pop_front(); m_e = m_t.v; end
        chk("pix1", {15'd0, vld1, rgb1}, m_e);

        while (q_p3.size() > 0 && q_p3[0].cyc < cyc) begin
          chk("pix3_order", q_p3[0].cyc, cyc); m_t = q_p3.pop_front();
        end
        m_e = 32'd0;
        if (q_p3.size() > 0 && q_p3[0].cyc == cyc) begin m_t = q_p3.pop_front(); m_e = m_t.v; end
        chk("pix3", {15'd0, vld3, rgb3}, m_e);
      end
    end
  end

  // Drive one pixel for the current cycle and queue its reference response
  task automatic step(input int x, input int y, input bit de);
    int col, row, ox, oy, addr;
    bit ing, ok, hit;
    logic [3:0]  code;
    logic [15:0] rgb;
    exp_t t;
    pix_x  = 12'(x);
    pix_y  = 12'(y);
    pix_de = de;
    ing = de && x >= OX && x < OX + NCOL * CWID && y >= OY && y < OY + NROW * CHGT;
    col = 0; row = 0; ox = 0; oy = 0;
    if (ing) begin
      col = (x - OX) / CWID;  ox = (x - OX) % CWID;
      row = (y - OY) / CHGT;  oy = (y - OY) % CHGT;
    end
    code = ing ? board[row][col] : 4'd0;
    ok   = ing && (int'(code) < NTIL);
    addr = ok ? int'(code) * CWID * CHGT + oy * CWID + ox : 0;
    hit  = ing && cursor_en && col == int'(cursor_col) && row == int'(cursor_row)
        && (ox == 0 || ox == CWID - 1 || oy == 0 || oy == CHGT - 1);
    if (!de)      rgb = 16'h0000;
    else if (!ok) rgb = BG;
    else if (hit) rgb = CUR;
    else          rgb = rom_f(addr);
    if (sys_rst_n) begin
      t.cyc = cyc + 1; t.v = {25'd0, ing, col[2:0], row[2:0]}; q_rd.push_back(t);
      t.cyc = cyc + 3; t.v = addr;                              q_ad.push_back(t);
      t.cyc = cyc + 5; t.v = {15'd0, de, rgb};                  q_p1.push_back(t);
      t.cyc = cyc + 7;                                          q_p3.push_back(t);
    end
    @(posedge vga_clk);
    #1;
  endtask

  // Cursor changes are placed between idle pixels
  task automatic set_cursor(input bit en, input int c, input int r);
    step(0, 0, 0);
    cursor_en  = en;
    cursor_col = 3'(c);
    cursor_row = 3'(r);
    step(0, 0, 0);
  endtask

  // Assert reset for n cycles with live pixels; pipeline contents are dropped
  task automatic do_reset(input int n);
    exp_t t;
    sys_rst_n = 1'b0;
    while (q_rd.size() > 0 && q_rd[$].cyc > cyc) t = q_rd.pop_back();
    while (q_ad.size() > 0 && q_ad[$].cyc > cyc) t = q_ad.pop_back();
    while (q_p1.size() > 0 && q_p1[$].cyc > cyc) t = q_p1.pop_back();
    while (q_p3.size() > 0 && q_p3[$].cyc > cyc) t = q_p3.pop_back();
    repeat (n) step($urandom_range(150, 500), $urandom_range(80, 400), 1'b1);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n  = 1'b0;
    pix_x      = '0;
    pix_y      = '0;
    pix_de     = 1'b0;
    cursor_en  = 1'b0;
    cursor_col = '0;
    cursor_row = '0;
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++)
        board[r][c] = 4'($urandom_range(0, NTIL - 1));
    board[0][0] = 4'd3;
    board[7][7] = 4'd11;
    board[2][3] = 4'd13;
    board[5][2] = 4'd4;
    @(posedge vga_clk);
    #1;
    do_reset(3);

    // Directed corner cases
    step(192, 112, 1);
    step(447, 367, 1);
    step(448, 112, 1);
    step(191, 200, 1);
    step(300, 300, 0);
    set_cursor(1, 2, 5);
    step(256, 272, 1);
    step(257, 273, 1);
    step(287, 300, 1);
    set_cursor(0, 2, 5);
    step(256, 272, 1);
    step(300, 200, 1);

    // Full lines, including wrap to the next line
    for (int x = 0; x < 640; x++) step(x, 150, 1);
    for (int x = 0; x < 640; x++) step(x, 367, 1);

    // New board with invalid codes, then random jumps with cursor moves
    repeat (10) step(0, 0, 0);
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++)
        board[r][c] = 4'($urandom);
    set_cursor(1, 0, 0);
    for (int i = 0; i < 1200; i++) begin
      if (i % 100 == 50) set_cursor(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
      step($urandom_range(150, 500), $urandom_range(80, 400), ($urandom % 8) != 0);
    end

    // Reset in the middle of a line
    set_cursor(1, 3, 4);
    for (int x = 0; x < 640; x++) begin
      if (x == 320) do_reset(2);
      step(x, 250, 1);
    end

    repeat (12) step(0, 0, 0);
    repeat (10) @(posedge vga_clk);
    #1;
    chk("queues_drained", q_rd.size() + q_ad.size() + q_p1.size() + q_p3.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cell_tile_fetch.md
Name: cell_tile_fetch

Overview:
- Parametrised successor to the per-image cell ROM driver.
- Maps the VGA pixel stream onto a GRID_COLS x GRID_ROWS minesweeper board.
- Reads each cell's state code from the board-state memory, addresses one unified tile ROM holding all cell images, compensates the ROM read latency, and adds a cursor-border highlight.
- Sits between the VGA timing generator and the final colour mux.

Parameters:
- COLOR_W, 16, pixel colour width (RGB565).
- ORIGIN_X, 192, screen x of the grid's left edge.
- ORIGIN_Y, 112, screen y of the grid's top edge.
- CELL_W, 32, cell width in pixels; any value ≥2, power of two not required.
- CELL_H, 32, cell height in pixels; any value ≥2.
- GRID_COLS, 8, board columns (≥2).
- GRID_ROWS, 8, board rows (≥2).
- TILE_TYPES, 12, number of tile images in ROM; codes 0-8 = counts, 9 = mine, 10 = flag, 11 = unshown.
- ROM_LAT, 1, tile ROM read latency in cycles (≥1).
- BG_COLOR, 16'h0000, colour for grid-off pixels and invalid codes.
- CURSOR_COLOR, 16'hF800, cursor border colour.
- Localparams (derived): CW = clog2(GRID_COLS), RW = clog2(GRID_ROWS), RAW = clog2(TILE_TYPES*CELL_W*CELL_H).

Ports:
- vga_clk  in  1  pixel clock; sole clock.
- sys_rst_n  in  1  synchronous active-low reset.
- pix_x  in  12  current pixel column.
- pix_y  in  12  current pixel row.
- pix_de  in  1  active-display qualifier for pix_x/pix_y.
- cursor_en  in  1  enable cursor highlight.
- cursor_col  in  CW  cursor cell column.
- cursor_row  in  RW  cursor cell row.
- cell_rd_en  out  1  board-state read strobe.
- cell_rd_col  out  CW  board-state read column.
- cell_rd_row  out  RW  board-state read row.
- cell_code  in  4  board-state data, valid exactly 1 cycle after cell_rd_en.
- rom_addr  out  RAW  unified tile ROM address.
- rom_data  in  COLOR_W  ROM output, valid ROM_LAT cycles after rom_addr.
- pix_rgb  out  COLOR_W  output colour.
- pix_rgb_vld  out  1  pix_rgb corresponds to a pix_de pixel.

Behaviour:
- One clock domain, vga_clk. Reset is synchronous and active-low: sys_rst_n is sampled on vga_clk rising edges.
- While sys_rst_n=0: all outputs are 0 and all pipeline valid bits are cleared.
- Reset asserted mid-frame: outputs are 0 from the next edge, and no stale pixel emerges after release.
- Definitions for the pixel sampled in cycle t:
  - in_grid = pix_de && ORIGIN_X ≤ pix_x < ORIGIN_X+GRID_COLS*CELL_W && ORIGIN_Y ≤ pix_y < ORIGIN_Y+GRID_ROWS*CELL_H.
  - col = (pix_x-ORIGIN_X)/CELL_W, ox = (pix_x-ORIGIN_X)%CELL_W.
  - row = (pix_y-ORIGIN_Y)/CELL_H, oy = (pix_y-ORIGIN_Y)%CELL_H.
  - No combinational divider may be used. Running counters are permitted only if their results equal these formulas for arbitrary pix_x/pix_y sequences; otherwise use a constant-divisor reduction.
- Pipeline for the pixel sampled in cycle t:
  - t+1: cell_rd_en=in_grid, with cell_rd_col=col and cell_rd_row=row. When in_grid=0, col/row are driven 0.
  - t+2: cell_code is sampled.
  - t+3: rom_addr = code*CELL_W*CELL_H + oy*CELL_W + ox. The multiplier is constant-only. If in_grid=0 or code ≥ TILE_TYPES, rom_addr=0.
  - t+3+ROM_LAT: rom_data is sampled.
  - t+4+ROM_LAT: pix_rgb and pix_rgb_vld are registered. Total latency = 4+ROM_LAT (5 at default); throughput is 1 pixel/cycle, with no stalls.
- pix_x, pix_y, pix_de, in_grid, ox, oy, a code-valid flag and a cursor-hit flag are delay-lined so they align with rom_data.
- Output select, in priority order:
  - pix_de=0: pix_rgb=0, vld=0.
  - in_grid=0: BG_COLOR, vld=1.
  - code ≥ TILE_TYPES: BG_COLOR, vld=1.
  - Cursor hit (cursor_en && col==cursor_col && row==cursor_row) and border pixel (ox==0, ox==CELL_W-1, oy==0 or oy==CELL_H-1): CURSOR_COLOR, vld=1.
  - Otherwise: rom_data, vld=1.
- cursor_en, cursor_col and cursor_row are sampled at t+1 alongside the cell read, so a cursor change takes effect on exactly the pixels sampled after it.
- Non-consecutive pixel coordinates (jumps, line wrap, frame wrap) produce results identical to the formulas; there is no history dependence.

Test Plan:
- Reset, then pix_de=1 at (192,112) with cell_code=3 → cell_rd_col/row=0/0 at t+1, rom_addr=3072 at t+3, pix_rgb=rom_data at t+5.
- Pixel (447,367) with code 11 → col 7, row 7, rom_addr=12287, pix_rgb_vld=1.
- Pixel (448,112), then (191,200) → cell_rd_en=0, pix_rgb=BG_COLOR, vld=1; pix_de=0 → pix_rgb=0, vld=0.
- cursor_en=1 at (2,5): pixel (256,272) → CURSOR_COLOR; pixel (257,273) → rom_data; pixel (287,300) → CURSOR_COLOR; cursor_en=0 → rom_data.
- Code 13 at (300,200) → BG_COLOR, rom_addr=0.
- Full 640-pixel line streamed with ROM_LAT=1, then repeated with ROM_LAT=3 → output equals the reference model shifted by 5 and 7 cycles respectively. Assert sys_rst_n=0 mid-line → outputs 0 next cycle; after release, the first vld appears 4+ROM_LAT cycles after the first pix_de.
